rv_cpu: RTL and testbench
=========================

Name: rv_cpu

Overview:
- Single-cycle RV32I integer execute core; one instruction word is supplied on `instr` every clock, with no fetch path or instruction memory inside the block.
- Contains a program counter, a 32x32 register file, decode logic and an ALU.
- Reports the value written back to the destination register on `rd_out`.
- Sits below the fetch/memory wrapper; used stand-alone for instruction-level verification.

Parameters:
- XLEN, 32, datapath and register width (only 32 supported).
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- instr  input  32  instruction executed at the next rising edge.
- rd_out  output  32  registered copy of the last value written back to rd.

Behaviour:
- Reset (rst=0), asynchronous:
  - all 32 registers clear to 0.
  - PC set to RESET_PC.
  - rd_out set to 0.
  - Any in-flight instruction is discarded; execution resumes at the first rising edge after rst returns to 1.
- Per rising edge with rst=1:
  - decode `instr` combinationally and compute the result.
  - write rf[rd] and rd_out in that same edge.
  - update PC.
  - Latency: one edge; rd_out reflects `instr` sampled at the preceding edge.
- Supported opcodes:
  - LUI 0110111: result = {imm[31:12], 12'b0}.
  - AUIPC 0010111: result = PC + {imm[31:12], 12'b0}.
  - JAL 1101111: result = PC+4; next PC = PC + sext J-imm.
  - JALR 1100111: result = PC+4; next PC = (rs1 + sext I-imm) & ~1. The old rs1 is used when rd==rs1.
  - OP-IMM 0010011: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI. Shift amount is imm[4:0]; imm[30] selects SRAI.
  - OP 0110011: ADD, SUB (funct7[5]), SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. Shift amount is rs2[4:0].
  - BRANCH 1100011: BEQ, BNE, BLT, BGE, BLTU, BGEU. No writeback, rd_out holds; next PC = PC + sext B-imm if taken, else PC+4.
- All other opcodes/funct combinations, including loads, stores, FENCE and SYSTEM:
  - no register write, rd_out holds.
  - next PC = PC+4.
- Arithmetic:
  - modulo 2^32, no overflow flags.
  - SLT/BLT/BGE signed; SLTU/BLTU/BGEU unsigned; SLT results are 0 or 1.
- Register x0:
  - reads always 0.
  - a writeback with rd=0 does not modify x0 and drives rd_out to 0.
- Register file has two combinational read ports and one write port; a read after a write in the next cycle returns the new value.
- PC:
  - default next PC is PC+4.
  - no misalignment trap; target bit 1 is ignored (treated as 0).

Optional Feature:
- Macro CPU_MUL_EN.
- Defined: OP with funct7=0000001 and funct3=000 executes MUL, result = low 32 bits of rs1*rs2, written to rd and rd_out.
- Other funct7=0000001 encodings are treated as unsupported (no write, PC+4).
- Undefined: every funct7=0000001 encoding is unsupported (no write, rd_out holds, PC+4).

Test Plan:
- Reset: rst=0 then 1, then LUI x5 0xABCDE (instr 32'hABCDE2B7) for one edge -> rd_out=32'hABCDE000, x5=32'hABCDE000; holding the same instr keeps rd_out unchanged.
- ADDI x1,x0,-1 then ADDI x2,x0,5, then SUB x3,x2,x1 -> rd_out 32'hFFFFFFFF, 32'h00000005, 32'h00000006. SRAI x4,x1,4 -> 32'hFFFFFFFF; SRLI -> 32'h0FFFFFFF.
- ADDI x0,x0,7 -> rd_out=0; a following ADD x6,x0,x0 -> 0. SLTU x7,x0,x1 -> 1; SLT x7,x1,x0 -> 1.
- After reset, AUIPC x8,1 as the third instruction (PC=8) -> rd_out=32'h00001008. BEQ x0,x0,+16 -> rd_out holds, the next AUIPC x9,0 -> PC+16. JAL x1,+8 -> rd_out=PC+4.
- Assert rst=0 mid-sequence between edges -> rd_out=0 immediately, registers read 0, PC=0 afterwards. Store opcode (0100011) -> rd_out unchanged.
- With CPU_MUL_EN: rs1=7, rs2=6, MUL -> rd_out=42. Without CPU_MUL_EN: the same instr leaves rd_out unchanged.

Source files
------------

// File: rtl/rv_cpu.sv
// Single-cycle RV32I execute core: PC, 32x32 register file, decode and ALU.
// Optional macro CPU_MUL_EN adds the MUL instruction (OP, funct7=0000001, funct3=000).
module rv_cpu #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] rd_out
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  logic [XLEN-1:0] rf_q [32];
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] result;
  logic            wb_en;

  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2, shamt;
  logic [2:0] funct3;
  logic [XLEN-1:0] imm_i, imm_u, imm_b, imm_j;
  logic [XLEN-1:0] rs1_val, rs2_val, op_b, pc_plus4;
  logic            take;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // x0 is hard-wired to zero on the read side.
  assign rs1_val  = (rs1 == 5'd0) ? '0 : rf_q[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? '0 : rf_q[rs2];
  assign pc_plus4 = pc_q + 32'd4;

  // OP-IMM and OP share the ALU; only the second operand and shift amount differ.
  assign op_b  = (opcode == OpImm) ? imm_i : rs2_val;
  assign shamt = op_b[4:0];

  always_comb begin
    wb_en  = 1'b0;
    result = '0;
    pc_d   = pc_plus4;
    take   = 1'b0;
    unique case (opcode)
      OpLui: begin
        wb_en  = 1'b1;
        result = imm_u;
      end
      OpAuipc: begin
        wb_en  = 1'b1;
        result = pc_q + imm_u;
      end
      OpJal: begin
        wb_en  = 1'b1;
        result = pc_plus4;
        pc_d   = pc_q + imm_j;
      end
      OpJalr: begin
        if (funct3 == 3'b000) begin
          wb_en  = 1'b1;
          result = pc_plus4;
          pc_d   = (rs1_val + imm_i) & ~32'd1;
        end
      end
      OpImm, OpReg: begin
        wb_en = 1'b1;
        unique case (funct3)
          3'b000: result = rs1_val + op_b;
          3'b010: result = {31'b0, $signed(rs1_val) < $signed(op_b)};
          3'b011: result = {31'b0, rs1_val < op_b};
          3'b100: result = rs1_val ^ op_b;
          3'b110: result = rs1_val | op_b;
          3'b111: result = rs1_val & op_b;
          3'b001: result = rs1_val << shamt;
          default: result = instr[30] ? $unsigned($signed(rs1_val) >>> shamt)
                                      : rs1_val >> shamt;
        endcase
        if (opcode == OpImm) begin
          if (funct3 == 3'b001 && funct7 != 7'b0000000) wb_en = 1'b0;
          if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000) wb_en = 1'b0;
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000) result = rs1_val - rs2_val;
          else if (funct3 != 3'b101) wb_en = 1'b0;
`ifdef CPU_MUL_EN
        end else if (funct7 == 7'b0000001) begin
          wb_en  = (funct3 == 3'b000);
          result = rs1_val * rs2_val;
`endif
        end else if (funct7 != 7'b0000000) begin
          wb_en = 1'b0;
        end
      end
      OpBranch: begin
        unique case (funct3)
          3'b000:  take = (rs1_val == rs2_val);
          3'b001:  take = (rs1_val != rs2_val);
          3'b100:  take = $signed(rs1_val) < $signed(rs2_val);
          3'b101:  take = $signed(rs1_val) >= $signed(rs2_val);
          3'b110:  take = rs1_val < rs2_val;
          3'b111:  take = rs1_val >= rs2_val;
          default: take = 1'b0;
        endcase
        if (take) pc_d = pc_q + imm_b;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      pc_q   <= RESET_PC;
      rd_out <= '0;
    end else begin
      // No misalignment trap: the low two target bits are simply dropped.
      pc_q <= pc_d & ~32'd3;
      if (wb_en) begin
        if (rd != 5'd0) rf_q[rd] <= result;
        rd_out <= (rd == 5'd0) ? '0 : result;
      end
    end
  end

endmodule

// File: tb/tb_rv_cpu.sv
// Scoreboard bench for rv_cpu: directed instructions push expected rd_out values,
// a monitor pops and compares one entry per clock edge.
module tb_rv_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [31:0] rd_out;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];

`ifdef CPU_MUL_EN
  localparam logic [31:0] MulExp = 32'd42;
`else
  localparam logic [31:0] MulExp = 32'd6;
`endif

  rv_cpu dut (
    .clk    (clk),
    .rst    (rst),
    .instr  (instr),
    .rd_out (rd_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  task automatic compare(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: rd_out=%08h expected=%08h", nm, act, want);
    end
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] want, input string nm);
    exp_t e;
    instr  = ins;
    e.val  = want;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [31:0] ins, input logic [31:0] want, input string nm);
    @(negedge clk);
    push(ins, want, nm);
  endtask

  // Monitor: one expected entry per executed edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare(e.name, rd_out, e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: rd_out=%08h expected=finish", rd_out);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    compare("reset_rd_out", rd_out, 32'h0);
    // Release reset at a negedge together with the first instruction.
    push(32'hABCDE2B7, 32'hABCDE000, "lui_x5");
    rst = 1'b1;
    step(32'hABCDE2B7, 32'hABCDE000, "lui_hold");
    step(enc_u(20'h00001, 5'd8, 7'b0010111), 32'h00001008, "auipc_pc8");
    step(enc_i(12'h000, 5'd5, 3'b000, 5'd10, 7'b0010011), 32'hABCDE000, "x5_readback");
    step(enc_i(12'hFFF, 5'd0, 3'b000, 5'd1, 7'b0010011), 32'hFFFFFFFF, "addi_m1");
    step(enc_i(12'h005, 5'd0, 3'b000, 5'd2, 7'b0010011), 32'h00000005, "addi_5");
    step(enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd3), 32'h00000006, "sub");
    step(enc_i(12'h404, 5'd1, 3'b101, 5'd4, 7'b0010011), 32'hFFFFFFFF, "srai");
    step(enc_i(12'h004, 5'd1, 3'b101, 5'd4, 7'b0010011), 32'h0FFFFFFF, "srli");
    step(enc_i(12'h007, 5'd0, 3'b000, 5'd0, 7'b0010011), 32'h00000000, "addi_x0");
    step(enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd6), 32'h00000000, "add_x0_x0");
    step(enc_r(7'h00, 5'd1, 5'd0, 3'b011, 5'd7), 32'h00000001, "sltu");
    step(enc_r(7'h00, 5'd0, 5'd1, 3'b010, 5'd7), 32'h00000001, "slt");
    step(enc_b(13'd16, 5'd0, 5'd0, 3'b000), 32'h00000001, "beq_hold");
    step(enc_u(20'h0, 5'd9, 7'b0010111), 32'h00000044, "beq_target");
    step(enc_j(21'd8, 5'd1), 32'h0000004C, "jal_link");
    step(enc_u(20'h0, 5'd9, 7'b0010111), 32'h00000050, "jal_target");
    step(enc_b(13'd16, 5'd0, 5'd0, 3'b001), 32'h00000050, "bne_hold");
    step(enc_u(20'h0, 5'd9, 7'b0010111), 32'h00000058, "bne_fallthru");
    step(enc_s(12'h000, 5'd1, 5'd0, 3'b010), 32'h00000058, "store_hold");
    step(enc_i(12'h003, 5'd2, 3'b000, 5'd11, 7'b1100111), 32'h00000064, "jalr_link");
    step(enc_u(20'h0, 5'd9, 7'b0010111), 32'h00000008, "jalr_target");
    step(enc_i(12'h003, 5'd2, 3'b000, 5'd2, 7'b1100111), 32'h00000010, "jalr_rd_eq_rs1");
    step(enc_u(20'h0, 5'd9, 7'b0010111), 32'h00000008, "jalr_old_rs1");
    step(enc_i(12'h007, 5'd0, 3'b000, 5'd12, 7'b0010011), 32'h00000007, "addi_7");
    step(enc_i(12'h006, 5'd0, 3'b000, 5'd13, 7'b0010011), 32'h00000006, "addi_6");
    step(enc_r(7'h01, 5'd13, 5'd12, 3'b000, 5'd14), MulExp, "mul");
    step(enc_b(13'd16, 5'd0, 5'd10, 3'b110), MulExp, "bltu_hold");
    step(enc_b(13'd12, 5'd0, 5'd10, 3'b100), MulExp, "blt_hold");
    step(enc_u(20'h0, 5'd9, 7'b0010111), 32'h00000028, "blt_target");
    step(enc_i(12'hFFF, 5'd2, 3'b100, 5'd16, 7'b0010011), 32'hFFFFFFEF, "xori_x2");

    // Asynchronous reset between edges.
    @(negedge clk);
    #2 rst = 1'b0;
    #1 compare("async_reset", rd_out, 32'h0);
    @(negedge clk);
    push(enc_u(20'h0, 5'd9, 7'b0010111), 32'h00000000, "pc_after_reset");
    rst = 1'b1;
    step(enc_r(7'h00, 5'd2, 5'd5, 3'b000, 5'd17), 32'h00000000, "regs_cleared");
    step(enc_i(12'h000, 5'd16, 3'b000, 5'd18, 7'b0010011), 32'h00000000, "x16_cleared");

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
